// File: rtl/demux_8_32bit_regbank.sv
// 1-to-8 write demultiplexer with storage: decodes wa into eight WIDTH-bit
// registers and tracks per-entry valid bits plus an accepted-write counter.

module demux_8_32bit_regbank_entry #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] wd,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] d;

   // hold-vs-load 2:1 mux in front of the flops
   assign d = load ? wd : q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= '0;
      else       q <= d;
   end
endmodule

module demux_8_32bit_regbank_inc8 (
   input  logic [7:0] a,
   output logic [7:0] y
);
   logic [7:0] c;

   assign c[0] = 1'b1;
   for (genvar i = 0; i < 8; i++) begin : g_bit
      assign y[i] = a[i] ^ c[i];
      if (i < 7) begin : g_carry
         assign c[i+1] = a[i] & c[i];
      end
   end
endmodule

module demux_8_32bit_regbank #(
   parameter int WIDTH    = 32,
   parameter int ZERO_REG = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [2:0]       wa,
   input  logic [WIDTH-1:0] wd,
   input  logic             clr,
   output logic [WIDTH-1:0] q0,
   output logic [WIDTH-1:0] q1,
   output logic [WIDTH-1:0] q2,
   output logic [WIDTH-1:0] q3,
   output logic [WIDTH-1:0] q4,
   output logic [WIDTH-1:0] q5,
   output logic [WIDTH-1:0] q6,
   output logic [WIDTH-1:0] q7,
   output logic [7:0]       vld,
   output logic [7:0]       wr_cnt,
   output logic             wr_hit
);
   localparam logic ZR = (ZERO_REG != 0);

   logic [2:0]            wa_n;
   logic [7:0]            sel;
   logic [7:0]            load;
   logic                  accept;
   logic [7:0][WIDTH-1:0] q_arr;
   logic [7:0]            vld_d;
   logic [7:0]            cnt_base;
   logic [7:0]            cnt_inc;
   logic [7:0]            cnt_d;

   assign wa_n = ~wa;

   // AND/NOT decoder: each term picks wa or ~wa per address bit
   for (genvar i = 0; i < 8; i++) begin : g_dec
      localparam logic [2:0] IDX = 3'(i);
      assign sel[i] = (IDX[2] ? wa[2] : wa_n[2]) &
                      (IDX[1] ? wa[1] : wa_n[1]) &
                      (IDX[0] ? wa[0] : wa_n[0]);
      if (i == 0) begin : g_ld0
         assign load[i] = we & sel[i] & ~ZR;
      end else begin : g_ldn
         assign load[i] = we & sel[i];
      end
   end

   assign accept = |load;

   for (genvar i = 0; i < 8; i++) begin : g_ent
      if (i == 0 && ZERO_REG != 0) begin : g_zero
         assign q_arr[i] = '0;
      end else begin : g_reg
         demux_8_32bit_regbank_entry #(.WIDTH(WIDTH)) u_ent (
            .clk   (clk),
            .reset (reset),
            .load  (load[i]),
            .wd    (wd),
            .q     (q_arr[i])
         );
      end
   end

   assign q0 = q_arr[0];
   assign q1 = q_arr[1];
   assign q2 = q_arr[2];
   assign q3 = q_arr[3];
   assign q4 = q_arr[4];
   assign q5 = q_arr[5];
   assign q6 = q_arr[6];
   assign q7 = q_arr[7];

   // clr wipes history first, so a colliding write leaves only its own bit / a count of 1
   assign vld_d    = (vld & {8{~clr}}) | load;
   assign cnt_base = wr_cnt & {8{~clr}};

   demux_8_32bit_regbank_inc8 u_inc (
      .a (cnt_base),
      .y (cnt_inc)
   );

   assign cnt_d = accept ? cnt_inc : cnt_base;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld    <= 8'h00;
         wr_cnt <= 8'h00;
         wr_hit <= 1'b0;
      end else begin
         vld    <= vld_d;
         wr_cnt <= cnt_d;
         wr_hit <= accept;
      end
   end
endmodule

// File: tb/tb_demux_8_32bit_regbank.sv
// Randomized scoreboard bench: two instances (ZERO_REG=1 and 0) share stimulus
// and are checked against an array-based model of the register bank.

module tb_demux_8_32bit_regbank;
   typedef struct {
      logic [7:0][31:0] q;
      logic [7:0]       vld;
      logic [7:0]       cnt;
      logic             hit;
   } st_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        we = 1'b0;
   logic [2:0]  wa = 3'd0;
   logic [31:0] wd = 32'd0;
   logic        clr = 1'b0;

   logic [7:0][31:0] aq [2];
   logic [7:0]       avld [2];
   logic [7:0]       acnt [2];
   logic             ahit [2];

   st_t   model [2];
   st_t   expq0 [$];
   st_t   expq1 [$];
   string tagq0 [$];
   string tagq1 [$];
   string phase = "init";

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   demux_8_32bit_regbank #(.WIDTH(32), .ZERO_REG(1)) u_zr (
      .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .clr(clr),
      .q0(aq[0][0]), .q1(aq[0][1]), .q2(aq[0][2]), .q3(aq[0][3]),
      .q4(aq[0][4]), .q5(aq[0][5]), .q6(aq[0][6]), .q7(aq[0][7]),
      .vld(avld[0]), .wr_cnt(acnt[0]), .wr_hit(ahit[0])
   );

   demux_8_32bit_regbank #(.WIDTH(32), .ZERO_REG(0)) u_nz (
      .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .clr(clr),
      .q0(aq[1][0]), .q1(aq[1][1]), .q2(aq[1][2]), .q3(aq[1][3]),
      .q4(aq[1][4]), .q5(aq[1][5]), .q6(aq[1][6]), .q7(aq[1][7]),
      .vld(avld[1]), .wr_cnt(acnt[1]), .wr_hit(ahit[1])
   );

   function automatic st_t actual(int d);
      st_t s;
      s.q   = aq[d];
      s.vld = avld[d];
      s.cnt = acnt[d];
      s.hit = ahit[d];
      return s;
   endfunction

   task automatic compare(input int d, input string tag, input st_t e);
      st_t a;
      a = actual(d);
      vectors++;
      if (a.q !== e.q || a.vld !== e.vld || a.cnt !== e.cnt || a.hit !== e.hit) begin
         miscompares++;
         $display("FAIL %s dut%0d: got q=%h vld=%h cnt=%0d hit=%b, want q=%h vld=%h cnt=%0d hit=%b",
                  tag, d, a.q, a.vld, a.cnt, a.hit, e.q, e.vld, e.cnt, e.hit);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         model[d].q   = '0;
         model[d].vld = '0;
         model[d].cnt = '0;
         model[d].hit = 1'b0;
      end
   endtask

   // One rising edge of the register bank, described by its rules
   task automatic model_edge();
      int  idx;
      bit  acc;
      for (int d = 0; d < 2; d++) begin
         idx = int'(wa);
         acc = (we === 1'b1) && !(d == 0 && idx == 0);
         if (clr) begin
            model[d].vld = '0;
            model[d].cnt = '0;
         end
         if (acc) begin
            model[d].q[idx]   = wd;
            model[d].vld[idx] = 1'b1;
            model[d].cnt      = 8'((int'(model[d].cnt) + 1) % 256);
         end
         model[d].hit = acc;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (reset) model_reset();
      else       model_edge();
      expq0.push_back(model[0]); tagq0.push_back(phase);
      expq1.push_back(model[1]); tagq1.push_back(phase);
   endtask

   task automatic drive(input logic w, input logic [2:0] a, input logic [31:0] d, input logic c);
      we = w; wa = a; wd = d; clr = c;
      step();
   endtask

   // Asserts reset between edges and checks the asynchronous clear right away
   task automatic reset_mid();
      @(negedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      #1;
      compare(0, {phase, "_async_rst"}, model[0]);
      compare(1, {phase, "_async_rst"}, model[1]);
   endtask

   task automatic release_reset();
      step();
      reset = 1'b0;
   endtask

   initial begin : monitor
      st_t   e;
      string t;
      forever begin
         @(negedge clk);
         while (expq0.size() > 0) begin
            e = expq0.pop_front(); t = tagq0.pop_front();
            compare(0, t, e);
         end
         while (expq1.size() > 0) begin
            e = expq1.pop_front(); t = tagq1.pop_front();
            compare(1, t, e);
         end
      end
   end

   initial begin : stimulus
      model_reset();
      step();
      step();
      release_reset();

      phase = "pre";
      drive(1, 3'd4, 32'h12345678, 0);
      drive(1, 3'd7, 32'hCAFEF00D, 0);
      drive(0, 3'd0, 32'h0, 0);
      phase = "t1_reset";
      reset_mid();
      release_reset();
      phase = "t1_write";
      drive(1, 3'd3, 32'hDEADBEEF, 0);
      drive(0, 3'd0, 32'h0, 0);

      phase = "t2_zero";
      drive(1, 3'd0, 32'hFFFFFFFF, 0);
      drive(0, 3'd0, 32'h0, 0);

      phase = "t3_sweep";
      reset_mid();
      release_reset();
      for (int i = 1; i < 8; i++) drive(1, 3'(i), 32'h11111111 * i, 0);
      drive(0, 3'd0, 32'h0, 0);

      phase = "t4_wrap";
      reset_mid();
      release_reset();
      for (int i = 0; i < 300; i++) drive(1, 3'd5, 32'(i), 0);
      drive(0, 3'd0, 32'h0, 0);

      phase = "t5_clr";
      reset_mid();
      release_reset();
      for (int i = 1; i < 8; i++) drive(1, 3'(i), 32'h11111111 * i, 0);
      drive(1, 3'd2, 32'hA5A5A5A5, 1);
      drive(0, 3'd0, 32'h0, 0);
      drive(0, 3'd0, 32'h0, 1);

      phase = "t6_rst_write";
      we = 1'b1; wa = 3'd6; wd = 32'h66666666; clr = 1'b0;
      reset_mid();
      release_reset();
      we = 1'b0;
      step();
      drive(1, 3'd6, 32'h76543210, 0);
      drive(0, 3'd0, 32'h0, 0);

      phase = "x_addr";
      drive(0, 3'bxxx, 32'hBADBADBA, 0);

      phase = "random";
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 79) == 0) begin
            reset_mid();
            release_reset();
         end
         drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 19) == 0));
      end

      phase = "drain";
      drive(0, 3'd0, 32'h0, 0);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
